// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, owner encoding and default watchdog limit for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant-owner selection between ifu and lsu
// ports: ifu_req, lsu_req, last_winner (owner of the previous grant) -> owner
// ARB_ROUND_ROBIN_EN: on a tie, pick the requester that lost the previous grant;
// otherwise fixed priority with lsu over ifu.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic last_winner,
  output logic owner
);
`ifdef ARB_ROUND_ROBIN_EN
  assign owner = (ifu_req && lsu_req) ? ~last_winner : (lsu_req ? OWNER_LSU : OWNER_IFU);
`else
  logic unused;
  assign unused = ifu_req ^ last_winner;
  assign owner  = lsu_req ? OWNER_LSU : OWNER_IFU;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch (ifu) and load/store (lsu)
// ports: ifu_req/addr -> ifu_gnt/done/rdata/err; lsu_req/wen/addr/wdata/wmask -> lsu_gnt/done/rdata/err;
//        bus_req/wen/addr/wdata/wmask with bus_ready; bus_resp_valid/bus_rdata; busy
// ARB_ROUND_ROBIN_EN: enables round-robin tie-break via a last-winner register.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_gnt,
  output logic                  ifu_done,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [7:0]            lsu_wmask,
  output logic                  lsu_gnt,
  output logic                  lsu_done,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_err,
  output logic                  bus_req,
  input  logic                  bus_ready,
  output logic                  bus_wen,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [7:0]            bus_wmask,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  state_t                state;
  logic                  owner;
  logic                  pick;
  logic                  last;
  logic                  grant;
  logic [WW-1:0]         wd;
  logic [WW-1:0]         wd_inc;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  assign grant  = (state == IDLE) && (ifu_req || lsu_req);
  assign wd_inc = wd + WW'(1);
  mem_arb_pick u_pick (
    .ifu_req     (ifu_req),
    .lsu_req     (lsu_req),
    .last_winner (last),
    .owner       (pick)
  );
`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= OWNER_LSU;
    else if (grant) last <= pick;
`else
  assign last = OWNER_LSU;
`endif
  // grant is combinational so the requester sees it in the request cycle; masked while rst holds state in IDLE
  assign ifu_gnt   = !rst && grant && (pick == OWNER_IFU);
  assign lsu_gnt   = !rst && grant && (pick == OWNER_LSU);
  assign ifu_done  = (state == RESP) && (owner == OWNER_IFU);
  assign lsu_done  = (state == RESP) && (owner == OWNER_LSU);
  assign ifu_err   = err_q && (owner == OWNER_IFU);
  assign lsu_err   = err_q && (owner == OWNER_LSU);
  assign ifu_rdata = rdata_q;
  assign lsu_rdata = rdata_q;
  assign bus_req   = (state == REQ);
  assign busy      = (state != IDLE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWNER_IFU;
      bus_wen   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wmask <= '0;
      wd        <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner     <= pick;
          bus_wen   <= pick ? lsu_wen : 1'b0;
          bus_addr  <= pick ? lsu_addr : ifu_addr;
          bus_wdata <= pick ? lsu_wdata : '0;
          bus_wmask <= pick ? lsu_wmask : '0;
          err_q     <= 1'b0;
          state     <= REQ;
        end
        REQ: if (bus_ready) begin
          wd <= '0;
          if (bus_resp_valid) begin
            rdata_q <= bus_wen ? '0 : bus_rdata;
            state   <= RESP;
          end else state <= WAIT;
        end
        // watchdog counts WAIT cycles; expiry is judged on the incremented value
        WAIT: if (bus_resp_valid) begin
          rdata_q <= bus_wen ? '0 : bus_rdata;
          state   <= RESP;
        end else if (wd_inc == TMO) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          state   <= RESP;
        end else wd <= wd_inc;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic ifu_req = 0, lsu_req = 0, lsu_wen = 0;
  logic [31:0] ifu_addr = 0, lsu_addr = 0, bus_addr;
  logic [63:0] lsu_wdata = 0, bus_rdata = 0, ifu_rdata, lsu_rdata, bus_wdata;
  logic [7:0] lsu_wmask = 0, bus_wmask;
  logic ifu_gnt, ifu_done, ifu_err, lsu_gnt, lsu_done, lsu_err;
  logic bus_req, bus_wen, busy, bus_ready = 0, bus_resp_valid = 0;
  int total = 0, bad = 0, cyc = 0;
  int ready_lat = 0, resp_lat = 1, rcnt = 0, wcnt = 0;
  logic [63:0] resp_data = 0;
  bit manual = 0, pending = 0;
  typedef struct {logic lsu; logic [63:0] rdata; logic err; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_done(ifu_done),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_ready(bus_ready), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_resp_valid(bus_resp_valid),
    .bus_rdata(bus_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int rl, input int pl, input logic [63:0] d);
    ready_lat = rl;
    resp_lat = pl;
    resp_data = d;
  endtask
  task automatic expect_done(input logic lsu, input logic [63:0] d, input logic err, input int lat);
    q.push_back('{lsu, d, err, cyc + lat});
  endtask
  task automatic wait_done(input logic lsu, input int limit);
    bit seen = 0;
    int extra = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      tick();
      seen = lsu ? lsu_done : ifu_done;
      if (ifu_gnt || lsu_gnt) extra++;
    end
    chk(lsu ? "lsu_done_seen" : "ifu_done_seen", 64'(seen), 64'd1);
    chk("no_gnt_while_busy", 64'(extra), 64'd0);
    if (lsu) lsu_req = 0;
    else ifu_req = 0;
  endtask
  // bus model: accepts after ready_lat stall cycles, responds resp_lat cycles after acceptance (0 = same cycle, -1 = never)
  initial forever begin
    @(posedge clk);
    #1;
    if (!manual) begin
      bus_ready = 0;
      bus_resp_valid = 0;
      if (bus_req) begin
        if (rcnt < ready_lat) rcnt++;
        else begin
          bus_ready = 1;
          rcnt = 0;
          if (resp_lat == 0) begin
            bus_resp_valid = 1;
            bus_rdata = resp_data;
          end else begin
            pending = 1;
            wcnt = 0;
          end
        end
      end else if (pending && busy) begin
        wcnt++;
        if (wcnt == resp_lat) begin
          bus_resp_valid = 1;
          bus_rdata = resp_data;
          pending = 0;
        end
      end else pending = 0;
    end
  end
  // monitor: every done pulse is matched against the oldest expected completion
  always @(negedge clk) begin
    if (!rst && (ifu_done || lsu_done)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: ifu_done=%0b lsu_done=%0b expected none", ifu_done, lsu_done);
      end else begin
        e = q.pop_front();
        chk("done_owner", 64'(lsu_done), 64'(e.lsu));
        chk("done_both", 64'(ifu_done & lsu_done), 64'd0);
        chk("done_rdata", e.lsu ? lsu_rdata : ifu_rdata, e.rdata);
        chk("done_err", 64'(e.lsu ? lsu_err : ifu_err), 64'(e.err));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit first;
    tick();
    tick();
    chk("reset_ctrl", {ifu_gnt, ifu_done, ifu_err, lsu_gnt, lsu_done, lsu_err, bus_req, bus_wen, busy}, 0);
    chk("reset_data", ifu_rdata | lsu_rdata | bus_wdata | {32'b0, bus_addr} | {56'b0, bus_wmask}, 0);
    rst = 0;
    // single fetch, response one cycle after acceptance
    cfg(0, 1, 64'h00000013_00000093);
    tick();
    ifu_req = 1;
    ifu_addr = 32'h8000_0000;
    #1;
    chk("t1_ifu_gnt", ifu_gnt, 1);
    chk("t1_lsu_gnt", lsu_gnt, 0);
    expect_done(0, 64'h00000013_00000093, 0, 3);
    tick();
    chk("t1_bus", {bus_req, bus_wen, bus_addr}, {1'b1, 1'b0, 32'h8000_0000});
    wait_done(0, 10);
    tick();
    chk("t1_idle_no_regrant", {busy, ifu_gnt}, 0);
    // tie: lsu write wins, ifu follows after lsu_done
    cfg(0, 1, 64'h1234);
    ifu_req = 1;
    ifu_addr = 32'h8000_0040;
    lsu_req = 1;
    lsu_wen = 1;
    lsu_addr = 32'h8000_1000;
    lsu_wdata = 64'hDEADBEEF;
    lsu_wmask = 8'h0F;
    #1;
    chk("t2_tie_gnt", {ifu_gnt, lsu_gnt}, 2'b01);
    expect_done(1, 64'h0, 0, 3);
    tick();
    chk("t2_bus_addr", bus_addr, 32'h8000_1000);
    chk("t2_bus_wdata", bus_wdata, 64'hDEADBEEF);
    chk("t2_bus_ctl", {bus_req, bus_wen, bus_wmask}, {1'b1, 1'b1, 8'h0F});
    wait_done(1, 10);
    chk("t2_ifu_not_in_resp", ifu_gnt, 0);
    tick();
    chk("t2_ifu_gnt_after", ifu_gnt, 1);
    expect_done(0, 64'h1234, 0, 3);
    tick();
    chk("t2_ifu_bus", {bus_wen, bus_addr, bus_wmask}, {1'b0, 32'h8000_0040, 8'h00});
    wait_done(0, 10);
    tick();
    // lsu read with bus_ready held low for 5 cycles
    cfg(5, 1, 64'hCAFE);
    lsu_req = 1;
    lsu_wen = 0;
    lsu_addr = 32'h8000_2000;
    lsu_wdata = 0;
    lsu_wmask = 8'hFF;
    #1;
    chk("t3_lsu_gnt", lsu_gnt, 1);
    expect_done(1, 64'hCAFE, 0, 8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall", {bus_req, ifu_gnt, lsu_gnt, bus_ready, bus_addr, bus_wmask}, {4'b1000, 32'h8000_2000, 8'hFF});
    end
    wait_done(1, 10);
    tick();
    // second tie after an lsu win: round robin hands it to ifu
    cfg(0, 1, 64'hAAAA);
    first = !RR;
    ifu_req = 1;
    ifu_addr = 32'h8000_0080;
    lsu_req = 1;
    lsu_addr = 32'h8000_3000;
    #1;
    chk("t4_first_gnt", {ifu_gnt, lsu_gnt}, first ? 2'b01 : 2'b10);
    expect_done(first, 64'hAAAA, 0, 3);
    wait_done(first, 10);
    tick();
    chk("t4_second_gnt", {ifu_gnt, lsu_gnt}, first ? 2'b10 : 2'b01);
    expect_done(!first, 64'hAAAA, 0, 3);
    wait_done(!first, 10);
    tick();
    // no response: watchdog completion with err and zero data
    cfg(0, -1, 0);
    ifu_req = 1;
    ifu_addr = 32'h8000_0100;
    #1;
    chk("t5_gnt", ifu_gnt, 1);
    expect_done(0, 64'h0, 1, 10);
    wait_done(0, 20);
    tick();
    // accept and respond in the same cycle; exactly one done
    cfg(0, 0, 64'h77);
    ifu_req = 1;
    ifu_addr = 32'h8000_0200;
    #1;
    chk("t6_gnt", ifu_gnt, 1);
    expect_done(0, 64'h77, 0, 2);
    wait_done(0, 10);
    tick();
    chk("t6_single_done", {ifu_done, busy}, 0);
    // asynchronous reset while waiting, then a stale response
    cfg(0, -1, 0);
    ifu_req = 1;
    ifu_addr = 32'h8000_0300;
    tick();
    tick();
    chk("t7_in_wait", {busy, bus_req}, 2'b10);
    manual = 1;
    rst = 1;
    #1;
    bus_ready = 0;
    bus_resp_valid = 0;
    chk("t7_rst_ctrl", {ifu_gnt, ifu_done, ifu_err, lsu_gnt, lsu_done, lsu_err, bus_req, bus_wen, busy}, 0);
    chk("t7_rst_data", ifu_rdata | bus_wdata | {32'b0, bus_addr} | {56'b0, bus_wmask}, 0);
    ifu_req = 0;
    pending = 0;
    tick();
    rst = 0;
    bus_resp_valid = 1;
    bus_rdata = 64'hBAD;
    tick();
    bus_resp_valid = 0;
    tick();
    tick();
    chk("t7_no_late_done", {busy, ifu_done, lsu_done}, 0);
    chk("scoreboard_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
